ptp_assembler: RTL
==================

Name: ptp_assembler

Overview:
- Parametrised, clocked successor to the RAM data-input byte packer for the Manchester Baby memory path.
- Collects narrow chunks (default 8-bit) into wide words (default 32-bit) under valid/ready handshakes.
- Per-word selectable chunk order, synchronous partial-word flush, and a double-buffered output so the next word assembles while the previous one waits for the RAM write side.

Parameters:
- IN_W, 8: chunk width in bits.
- OUT_W, 32: word width in bits. Must be an integer multiple of IN_W.
- N, OUT_W/IN_W: derived chunks per word. N >= 2 required; elaboration fails otherwise.
- CW, $clog2(N): width of the chunk counter.

Ports:
- clk_i  in  1  rising-edge clock.
- reset_i  in  1  reset, asynchronous, active-high.
- clear_i  in  1  synchronous flush of the partial word.
- msb_first_i  in  1  order mode. 1 = first chunk lands in the MSBs; 0 = first chunk lands in the LSBs.
- in_valid_i  in  1  chunk valid.
- in_data_i  in  IN_W  chunk data.
- in_ready_o  out  1  chunk accept.
- out_valid_o  out  1  assembled word valid.
- out_data_o  out  OUT_W  assembled word.
- out_ready_i  in  1  word consumed.
- count_o  out  CW  chunks held in the accumulator for the current word.

Behaviour:
- Reset (async, reset_i=1):
  - acc=0, cnt=0, mode latch=1.
  - out_data_o=0, out_valid_o=0, count_o=0.
  - Reset mid-word or with a held word discards both.
- Chunk accept = in_valid_i & in_ready_o at the rising edge.
- Ready rule (combinational):
  - in_ready_o = ~clear_i & ~(cnt==N-1 & out_valid_o & ~out_ready_i).
  - Only the final chunk of a word stalls on a held output word; chunks 0..N-2 are always accepted.
- Mode latch:
  - On an accept with cnt==0, mode <= msb_first_i, and that chunk uses msb_first_i directly.
  - Chunks 1..N-1 use the latched mode. Changes to msb_first_i mid-word are ignored until the next word.
- Accumulate on accept:
  - MSB-first: acc_next = {acc[OUT_W-IN_W-1:0], in_data_i}.
  - LSB-first: acc_next = {in_data_i, acc[OUT_W-1:IN_W]}.
  - cnt <= cnt+1.
- Word completion (accept with cnt==N-1):
  - out_data_o <= acc_next, out_valid_o <= 1, cnt <= 0, acc <= 0.
  - Latency: word visible on the cycle after the final chunk's accept edge.
- Output handshake:
  - out_valid_o & out_ready_i at an edge consumes the word; out_valid_o <= 0 unless a completion occurs on the same edge.
  - Completion and consume on the same edge: new word loaded, out_valid_o stays 1. No bubble, no loss.
  - out_data_o holds stable while out_valid_o=1 and not consumed.
- clear_i=1 at an edge:
  - acc <= 0, cnt <= 0; no chunk accepted (in_ready_o=0).
  - The held output word and out_valid_o are unaffected; an output consume on the same edge still happens.
- count_o = cnt; wraps N-1 -> 0 only on completion.
- No overflow is possible: the final chunk is back-pressured, never dropped.

Test Plan:
- MSB-first, chunks 0x12,0x34,0x56,0x78 on consecutive cycles, out_ready_i=1 -> out_data_o=0x12345678, out_valid_o=1 for exactly one cycle after the 4th accept; count_o 0,1,2,3,0.
- msb_first_i=0, same chunks -> 0x78563412. Toggle msb_first_i after chunk 0 in either mode -> result unchanged.
- out_ready_i=0 after the first word, feed 8 chunks -> chunks 5-7 accepted; in_ready_o=0 with count_o=3 until out_ready_i=1. Then the 2nd word loads on the consume edge with no out_valid_o gap; out_data_o stable throughout the stall.
- Two chunks 0xAA,0xBB, then clear_i=1 while a word is held -> count_o=0, held word intact; next 4 chunks 0x01..0x04 give 0x01020304 (no 0xAA/0xBB residue).
- reset_i pulsed asynchronously between clock edges mid-word with out_valid_o=1 -> all outputs 0 immediately; first post-reset word assembles correctly.
- IN_W=4, OUT_W=16, MSB-first nibbles 0xA,0xB,0xC,0xD -> 0xABCD; N=4, CW=2.

Source files
------------

// File: rtl/ptp_assembler.sv
// Packs IN_W-bit chunks into OUT_W-bit words, per-word chunk order, double-buffered output.
// Latency: a word is visible on the cycle after its final chunk is accepted.
// Backpressure: only the final chunk of a word stalls while the held word is unconsumed.
module ptp_assembler #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 32,
    parameter int N     = OUT_W / IN_W,
    parameter int CW    = $clog2(N)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             msb_first_i,
    input  logic             in_valid_i,
    input  logic [IN_W-1:0]  in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [OUT_W-1:0] out_data_o,
    input  logic             out_ready_i,
    output logic [CW-1:0]    count_o
);

    generate
        if (N < 2 || N * IN_W != OUT_W) begin : g_bad_param
            $error("ptp_assembler: OUT_W must be a multiple of IN_W with N >= 2");
        end
    endgenerate

    logic [OUT_W-1:0] acc_dat;
    logic [OUT_W-1:0] acc_nxt;
    logic [CW-1:0]    cnt;
    logic             mode_q;
    logic             cur_msb;
    logic             last_chunk;
    logic             accept;
    logic             out_vld_q;
    logic [OUT_W-1:0] out_dat_q;

    assign last_chunk = (cnt == CW'(N - 1));
    assign in_ready_o = ~clear_i & ~(last_chunk & out_vld_q & ~out_ready_i);
    assign accept     = in_valid_i & in_ready_o;

    // The first chunk of a word takes the live order input; later chunks use the latched copy.
    assign cur_msb = (cnt == '0) ? msb_first_i : mode_q;

    always_comb begin
        acc_nxt = acc_dat;
        if (cur_msb) begin
            acc_nxt = {acc_dat[OUT_W-IN_W-1:0], in_data_i};
        end else begin
            acc_nxt = {in_data_i, acc_dat[OUT_W-1:IN_W]};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            acc_dat <= '0;
            cnt     <= '0;
            mode_q  <= 1'b1;
        end else if (clear_i) begin
            acc_dat <= '0;
            cnt     <= '0;
        end else if (accept) begin
            if (cnt == '0) begin
                mode_q <= msb_first_i;
            end
            if (last_chunk) begin
                acc_dat <= '0;
                cnt     <= '0;
            end else begin
                acc_dat <= acc_nxt;
                cnt     <= cnt + CW'(1);
            end
        end
    end

    // Completion wins over consume so a word finishing on the consume edge leaves no bubble.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
        end else if (accept && last_chunk) begin
            out_vld_q <= 1'b1;
            out_dat_q <= acc_nxt;
        end else if (out_ready_i) begin
            out_vld_q <= 1'b0;
        end
    end

    assign out_valid_o = out_vld_q;
    assign out_data_o  = out_dat_q;
    assign count_o     = cnt;

endmodule
